// File: rtl/ctrl_pkg.sv
// Shared control-bus layout for the input conditioner and the mode FSM.
package ctrl_pkg;

  localparam int CTRL_W         = 15;
  localparam int CTRL_VALUE_LSB = 0;
  localparam int CTRL_RSVD      = 8;
  localparam int CTRL_M_SEL     = 9;
  localparam int CTRL_T_SEL     = 10;
  localparam int CTRL_F_SEL     = 11;
  localparam int CTRL_ENTER     = 12;
  localparam int CTRL_MODE_LSB  = 13;

  // Keep only the highest-priority rising select (F > T > M); input/output are {f, t, m}.
  function automatic logic [2:0] sel_priority(input logic [2:0] rise_fm);
    logic [2:0] grant;
    grant = 3'b000;
    if (rise_fm[2]) begin
      grant = 3'b100;
    end else if (rise_fm[1]) begin
      grant = 3'b010;
    end else if (rise_fm[0]) begin
      grant = 3'b001;
    end else begin
      grant = 3'b000;
    end
    return grant;
  endfunction

endpackage

// File: rtl/control_bus_encoder_debounce.sv
// One-bit two-flop synchronizer followed by a stability-counting debouncer.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic clean
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             clean_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             clean_next_s;

  // Count how long the synchronized input has disagreed with the clean value.
  always_comb begin
    cnt_next_s   = {CNT_W{1'b0}};
    clean_next_s = clean_r;
    if (sync2_r != clean_r) begin
      if (cnt_r == CNT_LAST) begin
        clean_next_s = sync2_r;
        cnt_next_s   = {CNT_W{1'b0}};
      end else begin
        cnt_next_s   = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_next_s = {CNT_W{1'b0}};
    end
  end

  // Synchronizer, counter and clean-value registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      clean_r <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      cnt_r   <= cnt_next_s;
      clean_r <= clean_next_s;
    end
  end

  assign clean = clean_r;

endmodule

// File: rtl/control_bus_encoder.sv
// Conditions labkit buttons/switches into the 15-bit control bus for the mode FSM.
module control_bus_encoder
  import ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              btn_f,
  input  logic              btn_t,
  input  logic              btn_m,
  input  logic              btn_enter,
  input  logic [7:0]        sw_value,
  input  logic [1:0]        sw_mode,
  output logic [CTRL_W-1:0] controls
);

  // Raw bundle layout: [7:0] value, [9:8] mode, [10] M, [11] T, [12] F, [13] ENTER.
  logic [13:0]       raw_s;
  logic [13:0]       clean_s;
  logic [3:0]        btn_prev_r;
  logic [3:0]        rise_s;
  logic [2:0]        sel_s;
  logic              sel_any_s;
  logic              enter_req_s;
  logic              enter_fire_s;
  logic              enter_pend_r;
  logic              enter_pend_next_s;
  logic              value_chg_s;
  logic [1:0]        value_age_r;
  logic [1:0]        value_age_next_s;
  logic [CTRL_W-1:0] ctrl_r;
  logic [CTRL_W-1:0] ctrl_next_s;

  assign raw_s = {btn_enter, btn_f, btn_t, btn_m, sw_mode, sw_value};

  for (genvar g = 0; g < 14; g++) begin : g_deb
    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock (clock),
      .reset (reset),
      .din   (raw_s[g]),
      .clean (clean_s[g])
    );
  end

  // Edge detection, select priority, ENTER sequencing and next bus value.
  always_comb begin
    rise_s      = clean_s[13:10] & ~btn_prev_r;
    sel_s       = sel_priority(rise_s[2:0]);
    sel_any_s   = |sel_s;
    value_chg_s = (clean_s[7:0] != ctrl_r[CTRL_VALUE_LSB +: 8]);

    value_age_next_s = 2'd0;
    if (value_chg_s) begin
      value_age_next_s = 2'd0;
    end else if (value_age_r == 2'd3) begin
      value_age_next_s = 2'd3;
    end else begin
      value_age_next_s = value_age_r + 2'd1;
    end

    // The ENTER pulse and the age it is gated by become visible on the same edge,
    // so the gate looks at the age the bus will carry alongside the pulse.
    enter_req_s  = enter_pend_r | rise_s[3];
    enter_fire_s = enter_req_s & ~sel_any_s & (value_age_next_s >= 2'd2);
    enter_pend_next_s = enter_req_s & ~enter_fire_s;

    ctrl_next_s                        = {CTRL_W{1'b0}};
    ctrl_next_s[CTRL_VALUE_LSB +: 8]   = clean_s[7:0];
    ctrl_next_s[CTRL_RSVD]             = 1'b0;
    ctrl_next_s[CTRL_M_SEL]            = sel_s[0];
    ctrl_next_s[CTRL_T_SEL]            = sel_s[1];
    ctrl_next_s[CTRL_F_SEL]            = sel_s[2];
    ctrl_next_s[CTRL_ENTER]            = enter_fire_s;
    ctrl_next_s[CTRL_MODE_LSB +: 2]    = clean_s[9:8];
  end

  // Edge history, ENTER state, value age and the output bus register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_prev_r   <= 4'b0000;
      enter_pend_r <= 1'b0;
      value_age_r  <= 2'd0;
      ctrl_r       <= {CTRL_W{1'b0}};
    end else begin
      btn_prev_r   <= clean_s[13:10];
      enter_pend_r <= enter_pend_next_s;
      value_age_r  <= value_age_next_s;
      ctrl_r       <= ctrl_next_s;
    end
  end

  assign controls = ctrl_r;

endmodule

// File: tb/tb_control_bus_encoder.sv
// Directed bench for control_bus_encoder with DEBOUNCE_CYCLES = 4.
module tb_control_bus_encoder;

  logic        clock;
  logic        reset;
  logic        btn_f;
  logic        btn_t;
  logic        btn_m;
  logic        btn_enter;
  logic [7:0]  sw_value;
  logic [1:0]  sw_mode;
  logic [14:0] controls;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  control_bus_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_f     (btn_f),
    .btn_t     (btn_t),
    .btn_m     (btn_m),
    .btn_enter (btn_enter),
    .sw_value  (sw_value),
    .sw_mode   (sw_mode),
    .controls  (controls)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clear_inputs();
    btn_f = 1'b0; btn_t = 1'b0; btn_m = 1'b0; btn_enter = 1'b0;
    sw_value = 8'h00; sw_mode = 2'b00;
  endtask

  // Known idle state: inputs low, reset pulse, settle long enough for value age to saturate.
  task automatic do_reset();
    @(negedge clock);
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (12) @(negedge clock);
  endtask

  task automatic test_reset();
    logic [14:0] exp;
    @(negedge clock);
    reset = 1'b0;
    btn_f = 1'b1; btn_t = 1'b1; btn_m = 1'b1; btn_enter = 1'b1;
    sw_value = 8'hFF; sw_mode = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk_cnt++;
      if (controls !== 15'h0000) $display("FAIL reset_hold cyc=%0d got=%h exp=0000", k, controls);
      else pass_cnt++;
    end
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock); @(negedge clock);
      if (k < 7)       exp = 15'h0000;
      else if (k == 7) exp = 15'h68FF;
      else if (k == 9) exp = 15'h70FF;
      else             exp = 15'h60FF;
      chk_cnt++;
      if (controls !== exp) $display("FAIL reset_release cyc=%0d got=%h exp=%h", k, controls, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_select_t();
    logic [14:0] exp;
    @(negedge clock);
    btn_t = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock); @(negedge clock);
      exp = (k == 7) ? 15'h0400 : 15'h0000;
      chk_cnt++;
      if (controls !== exp) $display("FAIL t_pulse cyc=%0d got=%h exp=%h", k, controls, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    @(negedge clock);
    btn_m = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock); @(negedge clock);
      if (k == 3) btn_m = 1'b0;
      chk_cnt++;
      if (controls !== 15'h0000) $display("FAIL m_glitch cyc=%0d got=%h exp=0000", k, controls);
      else pass_cnt++;
    end
  endtask

  task automatic test_priority();
    logic [14:0] exp;
    @(negedge clock);
    btn_f = 1'b1; btn_m = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock); @(negedge clock);
      exp = (k == 7) ? 15'h0800 : 15'h0000;
      chk_cnt++;
      if (controls !== exp) $display("FAIL f_over_m cyc=%0d got=%h exp=%h", k, controls, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_enter_value_age();
    logic [14:0] exp;
    @(negedge clock);
    sw_value = 8'h5A;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clock); @(negedge clock);
      if (k == 1) btn_enter = 1'b1;
      if (k < 7)       exp = 15'h0000;
      else if (k == 9) exp = 15'h105A;
      else             exp = 15'h005A;
      chk_cnt++;
      if (controls !== exp) $display("FAIL enter_age cyc=%0d got=%h exp=%h", k, controls, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] exp;
    @(negedge clock);
    btn_enter = 1'b1; btn_t = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock); @(negedge clock);
      if (k == 7)      exp = 15'h0400;
      else if (k == 8) exp = 15'h1000;
      else             exp = 15'h0000;
      chk_cnt++;
      if (controls !== exp) $display("FAIL t_then_enter cyc=%0d got=%h exp=%h", k, controls, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_pending();
    @(negedge clock);
    sw_mode = 2'b10;
    repeat (10) @(negedge clock);
    chk_cnt++;
    if (controls !== 15'h4000) $display("FAIL mode_setup got=%h exp=4000", controls);
    else pass_cnt++;
    btn_enter = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clock); @(negedge clock);
    end
    reset = 1'b0;
    #1;
    chk_cnt++;
    if (controls !== 15'h0000) $display("FAIL reset_async got=%h exp=0000", controls);
    else pass_cnt++;
    btn_enter = 1'b0; sw_mode = 2'b00;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clock); @(negedge clock);
      chk_cnt++;
      if (controls !== 15'h0000) $display("FAIL no_enter_after_reset cyc=%0d got=%h exp=0000", k, controls);
      else pass_cnt++;
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
    do_reset();
    test_select_t();
    do_reset();
    test_glitch();
    do_reset();
    test_priority();
    do_reset();
    test_enter_value_age();
    do_reset();
    test_back_to_back();
    do_reset();
    test_reset_pending();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
